// File: rtl/lut_sched_pkg.sv
// rtl/lut_sched_pkg.sv - shared state encoding and size helpers for the LUT layer scheduler
package lut_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Truth-table width for a LUT with the given number of address bits.
    function automatic int tt_width(input int fanin);
        return 1 << fanin;
    endfunction

    // Number of evaluation cycles needed to cover the whole layer.
    function automatic int beat_count(input int neurons, input int lanes);
        return neurons / lanes;
    endfunction

    // Beat counter width; never narrower than one bit.
    function automatic int beat_cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/lut_lane.sv
// rtl/lut_lane.sv - one evaluation lane: selects a single truth-table bit by address
//
// Ports:
//   tt     truth table, bit a is the output for address a
//   addr   LUT address
//   result selected table bit
module lut_lane
    import lut_sched_pkg::*;
#(
    parameter int FANIN = 6
) (
    input  logic [tt_width(FANIN)-1:0] tt,
    input  logic [FANIN-1:0]           addr,
    output logic                       result
);

    assign result = tt[addr];

endmodule

// File: rtl/lut_layer_scheduler.sv
// rtl/lut_layer_scheduler.sv - time-multiplexed evaluator for a layer of programmable LUT neurons
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   cfg_valid/cfg_ready/cfg_idx/cfg_table  truth-table write channel
//   cfg_err                           one-cycle pulse after an out-of-range table write
//   in_valid/in_ready/in_addr         inference request, per-neuron LUT addresses
//   out_valid/out_ready/out_data      layer result, one bit per neuron
//   busy                              high while evaluating or holding a result
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter int NEURONS = 16,
    parameter int FANIN   = 6,
    parameter int LANES   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [$clog2(NEURONS)-1:0]   cfg_idx,
    input  logic [tt_width(FANIN)-1:0]   cfg_table,
    output logic                         cfg_err,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NEURONS*FANIN-1:0]     in_addr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NEURONS-1:0]           out_data,
    output logic                         busy
);

    localparam int TT_W  = tt_width(FANIN);
    localparam int BEATS = beat_count(NEURONS, LANES);
    localparam int CW    = beat_cnt_width(BEATS);

    state_t                     state;
    logic [CW-1:0]              beat;
    logic [NEURONS*FANIN-1:0]   addr_q;
    logic [NEURONS-1:0]         res;
    logic [TT_W-1:0]            tables [NEURONS];

    logic [TT_W-1:0]            lane_tt   [LANES];
    logic [FANIN-1:0]           lane_addr [LANES];
    logic [LANES-1:0]           lane_bit;

    logic                       in_range;
    logic                       cfg_fire;
    logic                       in_fire;

    // Configuration wins over inference whenever both are offered in IDLE.
    assign cfg_ready = (state == IDLE);
    assign in_ready  = (state == IDLE) && !cfg_valid;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign in_fire   = in_valid && in_ready;
    assign in_range  = int'(cfg_idx) < NEURONS;
    assign out_data  = res;

    // Table store: writes only happen in IDLE, so tables are frozen for a
    // request from acceptance until its result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NEURONS; n++) begin
                tables[n] <= '0;
            end
        end else if (cfg_fire && in_range) begin
            for (int n = 0; n < NEURONS; n++) begin
                if (int'(cfg_idx) == n) begin
                    tables[n] <= cfg_table;
                end
            end
        end
    end

    // Lane l works on neuron beat*LANES + l in the current beat.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_tt[l]   = '0;
            lane_addr[l] = '0;
            for (int b = 0; b < BEATS; b++) begin
                if (int'(beat) == b) begin
                    lane_tt[l]   = tables[b*LANES + l];
                    lane_addr[l] = addr_q[(b*LANES + l)*FANIN +: FANIN];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lut_lane #(
            .FANIN (FANIN)
        ) u_lane (
            .tt     (lane_tt[l]),
            .addr   (lane_addr[l]),
            .result (lane_bit[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            addr_q    <= '0;
            res       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && !in_range;
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        addr_q <= in_addr;
                        beat   <= '0;
                        busy   <= 1'b1;
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    for (int b = 0; b < BEATS; b++) begin
                        if (int'(beat) == b) begin
                            for (int l = 0; l < LANES; l++) begin
                                res[b*LANES + l] <= lane_bit[l];
                            end
                        end
                    end
                    if (int'(beat) == BEATS - 1) begin
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        beat <= beat + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// tb/tb_lut_layer_scheduler.sv - scoreboard bench for lut_layer_scheduler
module tb_lut_layer_scheduler;

    logic         clk;
    logic         rst_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [3:0]   cfg_idx;
    logic [63:0]  cfg_table;
    logic         cfg_err;
    logic         in_valid;
    logic         in_ready;
    logic [95:0]  in_addr;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic         busy;

    // Second instance with a non-power-of-two layer so cfg_idx can be out of range.
    logic         e_cfg_valid;
    logic         e_cfg_ready;
    logic [3:0]   e_cfg_idx;
    logic [63:0]  e_cfg_table;
    logic         e_cfg_err;
    logic         e_in_valid;
    logic         e_in_ready;
    logic [71:0]  e_in_addr;
    logic         e_out_valid;
    logic         e_out_ready;
    logic [11:0]  e_out_data;
    logic         e_busy;

    int           tests;
    int           fails;
    logic [63:0]  tbl [16];
    logic [15:0]  exp_q [$];
    logic         rnd_mode;
    logic         prev_hold;
    logic [15:0]  prev_data;

    lut_layer_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_table (cfg_table),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    lut_layer_scheduler #(.NEURONS(12), .FANIN(6), .LANES(4)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (e_cfg_valid),
        .cfg_ready (e_cfg_ready),
        .cfg_idx   (e_cfg_idx),
        .cfg_table (e_cfg_table),
        .cfg_err   (e_cfg_err),
        .in_valid  (e_in_valid),
        .in_ready  (e_in_ready),
        .in_addr   (e_in_addr),
        .out_valid (e_out_valid),
        .out_ready (e_out_ready),
        .out_data  (e_out_data),
        .busy      (e_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting, expected handshake", name);
    endtask

    // Reference: output bit n is bit addr_n of neuron n's table.
    function automatic logic [15:0] model_eval(input logic [95:0] a);
        logic [15:0] r;
        for (int n = 0; n < 16; n++) begin
            r[n] = tbl[n][a[n*6 +: 6]];
        end
        return r;
    endfunction

    task automatic do_cfg(input logic [3:0] idx, input logic [63:0] tt);
        int cnt;
        cfg_idx   = idx;
        cfg_table = tt;
        cfg_valid = 1'b1;
        #1;
        cnt = 0;
        while (!cfg_ready && cnt < 300) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (!cfg_ready) begin
            timeout("cfg_handshake");
            cfg_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            tbl[idx] = tt;
            @(negedge clk);
            cfg_valid = 1'b0;
        end
    endtask

    task automatic do_inf(input logic [95:0] a);
        int cnt;
        in_addr  = a;
        in_valid = 1'b1;
        #1;
        cnt = 0;
        while (!in_ready && cnt < 300) begin
            @(negedge clk);
            #1;
            cnt++;
        end
        if (!in_ready) begin
            timeout("in_handshake");
            in_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            exp_q.push_back(model_eval(a));
            @(negedge clk);
            in_valid = 1'b0;
            in_addr  = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_drain();
        int cnt;
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        if (exp_q.size() != 0) timeout("drain");
        @(negedge clk);
        @(negedge clk);
    endtask

    function automatic logic [95:0] rand_addr();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Downstream backpressure changes just after the active edge.
    always @(posedge clk) begin
        #2;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares each accepted result against the scoreboard and
    // checks that a stalled result stays put.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %0h expected no result", out_data);
                end else begin
                    check("result", 64'(out_data), 64'(exp_q.pop_front()));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] a;
        logic [63:0] tt;
        logic [15:0] held;
        int          cnt;

        tests = 0;
        fails = 0;
        rnd_mode = 1'b0;
        prev_hold = 1'b0;
        prev_data = '0;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_idx = '0; cfg_table = '0;
        in_valid = 1'b0; in_addr = '0; out_ready = 1'b1;
        e_cfg_valid = 1'b0; e_cfg_idx = '0; e_cfg_table = '0;
        e_in_valid = 1'b0; e_in_addr = '0; e_out_ready = 1'b1;
        for (int n = 0; n < 16; n++) tbl[n] = '0;

        // Reset state
        @(negedge clk);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_err", 64'(cfg_err), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single programmed neuron
        do_cfg(4'd3, 64'h8000_0000_0000_0001);
        a = '0; a[3*6 +: 6] = 6'h3F;
        do_inf(a);
        wait_drain();
        a = '0; a[3*6 +: 6] = 6'h01;
        do_inf(a);
        wait_drain();

        // 2: latency and busy window
        check("t2_idle_busy", 64'(busy), 64'd0);
        do_inf(rand_addr());
        check("t2_busy_c11", 64'(busy), 64'd1);
        check("t2_valid_c11", 64'(out_valid), 64'd0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("t2_busy", 64'(busy), 64'd1);
            check("t2_valid", 64'(out_valid), (k == 4) ? 64'd1 : 64'd0);
        end
        @(negedge clk);
        check("t2_busy_c16", 64'(busy), 64'd0);
        check("t2_valid_c16", 64'(out_valid), 64'd0);
        wait_drain();

        // 3: simultaneous config and inference
        tt = {$urandom, $urandom};
        a = rand_addr();
        cfg_idx = 4'd5; cfg_table = tt; cfg_valid = 1'b1;
        in_addr = a; in_valid = 1'b1;
        #1;
        check("t3_in_ready_blocked", 64'(in_ready), 64'd0);
        check("t3_cfg_ready", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        tbl[5] = tt;
        @(negedge clk);
        cfg_valid = 1'b0;
        #1;
        check("t3_in_ready_next", 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(model_eval(a));
        @(negedge clk);
        in_valid = 1'b0;
        in_addr = rand_addr();
        wait_drain();

        // 4: backpressure in HOLD
        out_ready = 1'b0;
        do_inf(rand_addr());
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!out_valid) timeout("t4_out_valid");
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            check("t4_valid", 64'(out_valid), 64'd1);
            check("t4_data", 64'(out_data), 64'(held));
            check("t4_cfg_ready", 64'(cfg_ready), 64'd0);
            check("t4_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_busy_after", 64'(busy), 64'd0);
        check("t4_valid_after", 64'(out_valid), 64'd0);
        check("t4_cfg_ready_after", 64'(cfg_ready), 64'd1);
        wait_drain();

        // Randomized mix of writes and inferences under random backpressure
        rnd_mode = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0)
                do_cfg(4'($urandom_range(0, 15)), {$urandom, $urandom});
            else
                do_inf(rand_addr());
        end
        wait_drain();
        rnd_mode = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;

        // 5: reset during EVAL beat 2
        for (int n = 0; n < 16; n++) do_cfg(4'(n), '1);
        do_inf(rand_addr());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        for (int n = 0; n < 16; n++) tbl[n] = '0;
        #1;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_inf(rand_addr());
        wait_drain();

        // 6: out-of-range write on the 12-neuron instance
        e_cfg_valid = 1'b1; e_cfg_idx = 4'd2; e_cfg_table = '1;
        @(negedge clk);
        check("t6_err_valid_write", 64'(e_cfg_err), 64'd0);
        e_cfg_idx = 4'd12;
        @(negedge clk);
        check("t6_err_pulse", 64'(e_cfg_err), 64'd1);
        e_cfg_valid = 1'b0;
        @(negedge clk);
        check("t6_err_drop", 64'(e_cfg_err), 64'd0);
        e_in_addr = '0;
        e_in_valid = 1'b1;
        @(negedge clk);
        e_in_valid = 1'b0;
        cnt = 0;
        while (!e_out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (!e_out_valid) timeout("t6_out_valid");
        check("t6_data", 64'(e_out_data), 64'h004);

        @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
